instr_aligner: RTL



---
 rtl/instr_aligner.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_aligner.sv
// -----------------------------------------------------------------------------
// instr_aligner
//
// Sits between the fetch stage and the instruction decoder. It turns a stream
// of 32-bit fetch words into one aligned instruction per transfer. A
// compressed (RVC) instruction is delivered in [15:0] with [31:16] = 0. A full
// 32-bit (RVI) instruction is delivered as is. The block handles:
//   - instructions that straddle two fetch words,
//   - flush targets that start at half-word offset 2,
//   - per-half prediction marks,
//   - propagation of the fetch status of the source word(s).
//
// Ports
//   s_clk_i            clock
//   s_resetn_i         synchronous active-low reset
//   s_flush_i          pipeline flush / redirect (highest priority)
//   s_flush_offset_i   redirect target bit 1 (1 = start at upper half-word)
//   s_fetch_valid_i    fetch word valid
//   s_fetch_ready_o    fetch word consumed this cycle
//   s_fetch_instr_i    fetch word
//   s_fetch_error_i    fetch status of the word
//   s_fetch_pred_i     [0]/[1]: predicted-taken instruction starts in lower/upper half
//   s_valid_o          aligned instruction valid
//   s_ready_i          decoder accepts
//   s_instr_o          aligned instruction
//   s_fetch_error_o    combined fetch status
//   s_align_error_o    alignment / prediction inconsistency
//   s_prediction_o     prediction attached to the instruction
//   dbg_state_o        current FSM state (EMPTY=0, HALF=1, SKIP=2)
//
// Handshake rules
//   Output side: an instruction moves to the decoder when s_valid_o and
//   s_ready_i are both high in the same cycle. s_valid_o does not depend on
//   s_ready_i. Fetch side: s_fetch_ready_o is a "consumed" strobe. It is only
//   ever high together with s_fetch_valid_i, and the word is gone after that
//   edge. All outputs are combinational from the state and the current word.
//   State changes only on transfers and on flush.
// -----------------------------------------------------------------------------
module instr_aligner (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_flush_offset_i,
  input  logic        s_fetch_valid_i,
  output logic        s_fetch_ready_o,
  input  logic [31:0] s_fetch_instr_i,
  input  logic [2:0]  s_fetch_error_i,
  input  logic [1:0]  s_fetch_pred_i,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_instr_o,
  output logic [2:0]  s_fetch_error_o,
  output logic        s_align_error_o,
  output logic        s_prediction_o,
  output logic [1:0]  dbg_state_o
);

  // "No fetch error" encoding, matching the core-wide fetch status encoding.
  localparam logic [2:0] FETCH_VALID = 3'b000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no pending half-word
    HALF  = 2'd1,  // buffer holds an upper half-word still to be used
    SKIP  = 2'd2   // next word's lower half must be discarded (redirect to +2)
  } state_t;

  state_t      st_q, st_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  be_q, be_d;
  logic        bp_q, bp_d;

  logic [15:0] w_lo, w_hi;
  logic        lo_rvc, hi_rvc, b_rvc;
  logic        take;
  logic        straddle_aerr;

  assign w_lo   = s_fetch_instr_i[15:0];
  assign w_hi   = s_fetch_instr_i[31:16];
  assign lo_rvc = (w_lo[1:0] != 2'b11);
  assign hi_rvc = (w_hi[1:0] != 2'b11);
  assign b_rvc  = (b_q[1:0] != 2'b11);
  assign take   = s_ready_i;

  // A predicted jump on the buffered half means the next word is the jump
  // target, not the continuation. The same holds when the incoming word's
  // lower half is marked as a predicted-taken instruction start.
  assign straddle_aerr = bp_q | s_fetch_pred_i[0];

  assign dbg_state_o = st_q;

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      st_q <= EMPTY;
      b_q  <= '0;
      be_q <= '0;
      bp_q <= 1'b0;
    end else begin
      st_q <= st_d;
      b_q  <= b_d;
      be_q <= be_d;
      bp_q <= bp_d;
    end
  end

  always_comb begin
    st_d            = st_q;
    b_d             = b_q;
    be_d            = be_q;
    bp_d            = bp_q;
    s_valid_o       = 1'b0;
    s_fetch_ready_o = 1'b0;
    s_instr_o       = '0;
    s_fetch_error_o = '0;
    s_align_error_o = 1'b0;
    s_prediction_o  = 1'b0;

    if (!s_resetn_i) begin
      // Outputs stay quiet. The register reset takes care of the state.
    end else if (s_flush_i) begin
      // Drop whatever word is on the fetch interface and restart alignment.
      s_fetch_ready_o = s_fetch_valid_i;
      st_d            = s_flush_offset_i ? SKIP : EMPTY;
      b_d             = '0;
      be_d            = '0;
      bp_d            = 1'b0;
    end else begin
      case (st_q)
        EMPTY: begin
          if (s_fetch_valid_i) begin
            s_valid_o       = 1'b1;
            s_fetch_error_o = s_fetch_error_i;
            s_prediction_o  = s_fetch_pred_i[0];
            if (lo_rvc) begin
              s_instr_o = {16'b0, w_lo};
              if (take) begin
                s_fetch_ready_o = 1'b1;
                // After a predicted-taken RVC the upper half is off-path.
                if (!s_fetch_pred_i[0]) begin
                  b_d  = w_hi;
                  be_d = s_fetch_error_i;
                  bp_d = s_fetch_pred_i[1];
                  st_d = HALF;
                end
              end
            end else begin
              s_instr_o       = s_fetch_instr_i;
              // A prediction mark on the upper half of an RVI is inconsistent.
              s_align_error_o = s_fetch_pred_i[1];
              s_fetch_ready_o = take;
            end
          end
        end

        HALF: begin
          if (b_rvc) begin
            // The buffered half is a whole instruction and needs no new word.
            s_valid_o       = 1'b1;
            s_instr_o       = {16'b0, b_q};
            s_fetch_error_o = be_q;
            s_prediction_o  = bp_q;
            if (take) st_d = EMPTY;
          end else if (s_fetch_valid_i) begin
            s_valid_o       = 1'b1;
            s_instr_o       = {w_lo, b_q};
            s_prediction_o  = bp_q;
            // The first word's error wins. Otherwise report the second word's.
            s_fetch_error_o = (be_q != FETCH_VALID) ? be_q : s_fetch_error_i;
            s_align_error_o = straddle_aerr;
            if (take) begin
              s_fetch_ready_o = 1'b1;
              if (straddle_aerr) begin
                st_d = EMPTY;
              end else begin
                b_d  = w_hi;
                be_d = s_fetch_error_i;
                bp_d = s_fetch_pred_i[1];
              end
            end
          end
        end

        SKIP: begin
          if (s_fetch_valid_i) begin
            if (hi_rvc) begin
              s_valid_o       = 1'b1;
              s_instr_o       = {16'b0, w_hi};
              s_fetch_error_o = s_fetch_error_i;
              s_prediction_o  = s_fetch_pred_i[1];
              if (take) begin
                s_fetch_ready_o = 1'b1;
                st_d            = EMPTY;
              end
            end else begin
              // Nothing to emit yet. The word is absorbed into the buffer
              // whether or not the decoder is ready.
              s_fetch_ready_o = 1'b1;
              b_d             = w_hi;
              be_d            = s_fetch_error_i;
              bp_d            = s_fetch_pred_i[1];
              st_d            = HALF;
            end
          end
        end

        default: st_d = EMPTY;
      endcase
    end
  end

endmodule
